matrix_addr_gen: RTL and testbench
==================================

Name: matrix_addr_gen

Overview:
- Parametrised 2D address generator for matrix operand fetch/store in the MACC datapath. Successor to the fixed power-of-2 row/column counter.
- Supports arbitrary (non-power-of-2) row/column extents, a row pitch, a base address, and row-major or column-major traversal.
- Start/done handshake on the control side; valid/ready handshake on the address stream so the memory side can stall it.

Parameters:
- AW, 12, address width (addr, base, pitch)
- DW, 12, dimension width (rows, cols, row, col)

Ports:
- CLK  in  1  clock; all logic on posedge
- RST  in  1  reset, synchronous, active-high (fixed for this block)
- start  in  1  begin a traversal; honoured only in IDLE
- base  in  AW  address of element (0,0)
- pitch  in  AW  address distance between consecutive rows
- rows  in  DW  row count (0 = empty)
- cols  in  DW  column count (0 = empty)
- col_major  in  1  0: column index innermost; 1: row index innermost
- busy  out  1  high whenever state != IDLE
- out_valid  out  1  addr/row/col/last are valid
- out_ready  in  1  consumer accepts the current beat
- addr  out  AW  element address
- row  out  DW  row index of current beat
- col  out  DW  column index of current beat
- last  out  1  current beat is the final element
- done  out  1  one-cycle pulse, traversal complete

Behaviour:
- All outputs are registered. On RST: state=IDLE, busy=0, out_valid=0, done=0, last=0, addr=0, row=0, col=0.
- RST mid-traversal aborts immediately. No done pulse is produced. Latched config is discarded.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge N latches base/pitch/rows/cols/col_major. Config inputs are ignored at all other times.
  - If rows==0 or cols==0, go to DONE. No beats are emitted.
  - Otherwise go to RUN with row=0, col=0, addr=base, out_valid=1 visible in cycle N+1.
- RUN:
  - A beat transfers on any edge where out_valid && out_ready.
  - Without a transfer, addr/row/col/last hold stable and out_valid stays 1.
  - Row-major step: if col==cols-1 then col=0, row=row+1, addr=row_base+pitch, and row_base is updated; else col=col+1, addr=addr+1.
  - Column-major step: if row==rows-1 then row=0, col=col+1, addr=col_base+1, and col_base is updated; else row=row+1, addr=addr+pitch.
  - row_base/col_base are internal AW-bit registers, both loaded with base at start.
  - last = (row==rows-1) && (col==cols-1). It is registered alongside the beat, never combinational from out_ready.
  - A transfer with last=1 goes to DONE with out_valid=0 on the next cycle.
- DONE: done=1 for exactly one cycle, then IDLE. busy stays 1 during DONE and drops in the following cycle.
- Latency:
  - start to first out_valid: 1 cycle.
  - Transfer of last beat to done: done high the cycle after that edge.
  - Empty traversal: done high the cycle after start.
  - Maximum throughput is 1 beat/cycle with out_ready held high.
- Arithmetic: all address sums wrap modulo 2^AW, with no saturation or error flag. Index increments never exceed rows-1/cols-1. Total beats = rows*cols.
- start while busy: ignored, with no effect on the current traversal. start in the same cycle done is high is also ignored; a new traversal is accepted from IDLE only.
- No multiplier is used: addresses come only from add-by-1 and add-by-pitch.

Test Plan:
1. Row-major, base=0x100, pitch=8, rows=3, cols=5, out_ready=1 -> 15 consecutive beats:
   - addr 0x100-0x104, 0x108-0x10C, 0x110-0x114
   - (row,col) (0,0)..(2,4)
   - last only on beat 15; done one cycle later; busy low the cycle after done.
2. Same config with col_major=1 -> addr 0x100,0x108,0x110,0x101,0x109,0x111 … 0x114; row cycles 0,1,2 innermost; last on (2,4) at 0x114.
3. Case 1 with out_ready driven by a random 50% pattern -> identical beat sequence; addr/row/col/last stable across every stalled cycle; done exactly once.
4. rows=0, cols=7, start -> out_valid never asserts; done high the cycle after start. Repeat with rows=4, cols=0 -> same result.
5. Wrap case, AW=12, base=0xFFE, rows=2, cols=3, pitch=0x10:
   - beats 0xFFE, 0xFFF, 0x000, then 0x00E, 0x00F, 0x010
   - start pulsed mid-run -> ignored.
6. RST asserted on the 4th beat of case 1 -> next cycle out_valid=0, busy=0, done never pulses; a subsequent start restarts cleanly at 0x100.

Source files
------------

// File: rtl/matrix_addr_gen.sv
// matrix_addr_gen: 2D address generator for matrix operand fetch/store.
// Walks a rows x cols window in row-major or column-major order. Every
// address is formed by adding 1 or adding pitch, so no multiplier is needed.
// The address stream uses a valid/ready handshake, and the control side
// uses a start/done handshake.
module matrix_addr_gen #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW-1:0] pitch,
  input  logic [DW-1:0] rows,
  input  logic [DW-1:0] cols,
  input  logic          col_major,
  output logic          busy,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] row,
  output logic [DW-1:0] col,
  output logic          last,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pitch_q, pitch_d;
  logic [DW-1:0] rows_q, rows_d;
  logic [DW-1:0] cols_q, cols_d;
  logic          col_major_q, col_major_d;
  logic [AW-1:0] row_base_q, row_base_d;
  logic [AW-1:0] col_base_q, col_base_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] row_q, row_d;
  logic [DW-1:0] col_q, col_d;
  logic          last_q, last_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic          row_end;
  logic          col_end;

  assign row_end = (row_q == rows_q - DW'(1));
  assign col_end = (col_q == cols_q - DW'(1));

  // Next-state, traversal stepping, and registered output values
  always_comb begin
    state_d     = state_q;
    pitch_d     = pitch_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    col_major_d = col_major_q;
    row_base_d  = row_base_q;
    col_base_d  = col_base_q;
    addr_d      = addr_q;
    row_d       = row_q;
    col_d       = col_q;
    last_d      = last_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          pitch_d     = pitch;
          rows_d      = rows;
          cols_d      = cols;
          col_major_d = col_major;
          row_base_d  = base;
          col_base_d  = base;
          busy_d      = 1'b1;
          if ((rows == '0) || (cols == '0)) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_RUN;
            valid_d = 1'b1;
            addr_d  = base;
            row_d   = '0;
            col_d   = '0;
            last_d  = (rows == DW'(1)) && (cols == DW'(1));
          end
        end
      end

      S_RUN: begin
        if (valid_q && out_ready) begin
          if (last_q) begin
            state_d = S_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            if (!col_major_q) begin
              if (col_end) begin
                col_d      = '0;
                row_d      = row_q + DW'(1);
                addr_d     = row_base_q + pitch_q;
                row_base_d = row_base_q + pitch_q;
              end else begin
                col_d  = col_q + DW'(1);
                addr_d = addr_q + AW'(1);
              end
            end else begin
              if (row_end) begin
                row_d      = '0;
                col_d      = col_q + DW'(1);
                addr_d     = col_base_q + AW'(1);
                col_base_d = col_base_q + AW'(1);
              end else begin
                row_d  = row_q + DW'(1);
                addr_d = addr_q + pitch_q;
              end
            end
            last_d = (row_d == rows_q - DW'(1)) && (col_d == cols_q - DW'(1));
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_IDLE;
      pitch_q     <= '0;
      rows_q      <= '0;
      cols_q      <= '0;
      col_major_q <= 1'b0;
      row_base_q  <= '0;
      col_base_q  <= '0;
      addr_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      last_q      <= 1'b0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pitch_q     <= pitch_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      col_major_q <= col_major_d;
      row_base_q  <= row_base_d;
      col_base_q  <= col_base_d;
      addr_q      <= addr_d;
      row_q       <= row_d;
      col_q       <= col_d;
      last_q      <= last_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = valid_q;
  assign addr      = addr_q;
  assign row       = row_q;
  assign col       = col_q;
  assign last      = last_q;
  assign done      = done_q;

endmodule

// File: tb/tb_matrix_addr_gen.sv
// Scoreboard bench for matrix_addr_gen: stimulus queues expected beats,
// monitor checks every presented beat and the done pulse timing.
module tb_matrix_addr_gen;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        start = 1'b0;
  logic [11:0] base = '0;
  logic [11:0] pitch = '0;
  logic [11:0] rows = '0;
  logic [11:0] cols = '0;
  logic        col_major = 1'b0;
  logic        busy;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [11:0] addr;
  logic [11:0] row;
  logic [11:0] col;
  logic        last;
  logic        done;

  typedef struct packed {
    logic [11:0] addr;
    logic [11:0] row;
    logic [11:0] col;
    logic        last;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    errors = 0;
  logic  exp_done_next = 1'b0;

  matrix_addr_gen #(.AW(12), .DW(12)) dut (
    .CLK(CLK), .RST(RST), .start(start), .base(base), .pitch(pitch),
    .rows(rows), .cols(cols), .col_major(col_major), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .addr(addr), .row(row),
    .col(col), .last(last), .done(done)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Reference traversal: direct r*pitch + c formula, truncated to 12 bits
  task automatic push_model(input int b, input int p, input int r, input int c, input logic cm);
    beat_t bt;
    int    outer_n = cm ? c : r;
    int    inner_n = cm ? r : c;
    for (int o = 0; o < outer_n; o++) begin
      for (int i = 0; i < inner_n; i++) begin
        int rr = cm ? i : o;
        int cc = cm ? o : i;
        bt.addr = 12'(b + rr * p + cc);
        bt.row  = 12'(rr);
        bt.col  = 12'(cc);
        bt.last = (rr == r - 1) && (cc == c - 1);
        q.push_back(bt);
      end
    end
  endtask

  task automatic push_beat(input logic [11:0] a, input logic [11:0] r, input logic [11:0] c, input logic l);
    beat_t bt;
    bt.addr = a; bt.row = r; bt.col = c; bt.last = l;
    q.push_back(bt);
  endtask

  // Monitor: compare the presented beat against the queue head; pop on transfer
  always @(negedge CLK) begin
    if (RST) begin
      exp_done_next = 1'b0;
    end else begin
      chk("done_timing", 64'(done), 64'(exp_done_next));
      exp_done_next = 1'b0;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 64'(addr), 64'hFFFF_FFFF);
        end else begin
          chk("beat", 64'({addr, row, col, last}), 64'(q[0]));
          if (out_ready) begin
            if (q[0].last) exp_done_next = 1'b1;
            void'(q.pop_front());
          end
        end
      end
      if (start && ((rows == 12'd0) || (cols == 12'd0))) exp_done_next = 1'b1;
    end
  end

  // Entered and left at posedge+1. mode 0: ready high, 1: random ready, 2: mid-run start
  task automatic run(input logic [11:0] b, input logic [11:0] p, input logic [11:0] r,
                     input logic [11:0] c, input logic cm, input int mode);
    logic got = 1'b0;
    int   done_cnt = 0;
    out_ready = (mode != 1);
    base = b; pitch = p; rows = r; cols = c; col_major = cm;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    if (r == 0 || c == 0) begin
      chk("empty_done", 64'(done), 64'd1);
      chk("empty_valid", 64'(out_valid), 64'd0);
    end else begin
      chk("first_valid", 64'(out_valid), 64'd1);
      chk("first_busy", 64'(busy), 64'd1);
    end
    for (int n = 0; n < 500 && !got; n++) begin
      if (done) begin
        got = 1'b1;
        done_cnt++;
        chk("busy_in_done", 64'(busy), 64'd1);
      end else begin
        if (mode == 1) out_ready = 1'($urandom_range(0, 1));
        start = (mode == 2) && (n == 2);
        if ((mode == 2) && (n == 2)) base = 12'h000;
        @(posedge CLK); #1;
        start = 1'b0;
      end
    end
    if (!got) chk("done_timeout", 64'd0, 64'd1);
    @(posedge CLK); #1;
    if (done) done_cnt++;
    chk("done_once", 64'(done_cnt), 64'd1);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("valid_after_done", 64'(out_valid), 64'd0);
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_outs", 64'({addr, row, col, last}), 64'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Row-major, full throughput
    push_model(12'h100, 8, 3, 5, 1'b0);
    run(12'h100, 12'd8, 12'd3, 12'd5, 1'b0, 0);

    // Column-major, same window
    push_model(12'h100, 8, 3, 5, 1'b1);
    run(12'h100, 12'd8, 12'd3, 12'd5, 1'b1, 0);

    // Row-major with random stalls
    push_model(12'h100, 8, 3, 5, 1'b0);
    run(12'h100, 12'd8, 12'd3, 12'd5, 1'b0, 1);

    // Empty traversals
    run(12'h100, 12'd8, 12'd0, 12'd7, 1'b0, 0);
    run(12'h100, 12'd8, 12'd4, 12'd0, 1'b0, 0);

    // Address wrap with a start pulse mid-run
    push_beat(12'hFFE, 12'd0, 12'd0, 1'b0);
    push_beat(12'hFFF, 12'd0, 12'd1, 1'b0);
    push_beat(12'h000, 12'd0, 12'd2, 1'b0);
    push_beat(12'h00E, 12'd1, 12'd0, 1'b0);
    push_beat(12'h00F, 12'd1, 12'd1, 1'b0);
    push_beat(12'h010, 12'd1, 12'd2, 1'b1);
    run(12'hFFE, 12'h010, 12'd2, 12'd3, 1'b0, 2);

    // Single element
    push_beat(12'h0AB, 12'd0, 12'd0, 1'b1);
    run(12'h0AB, 12'd5, 12'd1, 12'd1, 1'b0, 0);

    // Reset on the 4th beat, then a clean restart
    push_model(12'h100, 8, 3, 5, 1'b0);
    out_ready = 1'b1;
    base = 12'h100; pitch = 12'd8; rows = 12'd3; cols = 12'd5; col_major = 1'b0;
    start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int n = 0; n < 50 && q.size() > 12; n++) begin
      @(posedge CLK); #1;
    end
    chk("rst_4th_beat_addr", 64'(addr), 64'h103);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk("abort_valid", 64'(out_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    RST = 1'b0;
    q.delete();
    repeat (3) begin
      @(posedge CLK); #1;
      chk("abort_no_done", 64'(done), 64'd0);
    end
    push_model(12'h100, 8, 3, 5, 1'b0);
    run(12'h100, 12'd8, 12'd3, 12'd5, 1'b0, 0);

    repeat (2) @(posedge CLK);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
